seg_scan_driver: RTL and testbench
==================================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clk cycles per digit slot, legal range 2..65535.
REQ-002 Parameter BLINK_FRAMES, default 64: full scan frames per blink half-period, legal range 1..255.
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 hr_ten  input  3  hours-tens BCD digit (legal 0..2).
REQ-006 hr_one  input  4  hours-units BCD digit (legal 0..9).
REQ-007 mn_ten  input  3  minutes-tens BCD digit (legal 0..5).
REQ-008 mn_one  input  4  minutes-units BCD digit (legal 0..9).
REQ-009 lz_blank  input  1  blank hours-tens digit when it is 0.
REQ-010 blink_en  input  1  blink whole display at BLINK_FRAMES rate.
REQ-011 colon_on  input  1  light dp on hours-units digit as separator.
REQ-012 seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-013 dp  output  1  decimal point, active-high.
REQ-014 com  output  4  digit commons, active-low, one-hot-low; bit 3 = hr_ten, bit 0 = mn_one.
REQ-015 frame_start  output  1  one-cycle pulse when snapshot of inputs is taken.

Function
REQ-016 Prescaler counts 0..SCAN_DIV-1 and wraps; slot tick asserted in the cycle it equals SCAN_DIV-1.
REQ-017 Slot index (2 bits) advances 3,2,1,0,3,... on each slot tick; slot 3 = hr_ten.
REQ-018 On the slot tick where index goes 0->3, all four digit inputs, lz_blank and colon_on are captured into a snapshot register and frame_start pulses for exactly that cycle.
REQ-019 Display outputs derive only from the snapshot, never from live inputs, so no digit changes mid-frame.
REQ-020 seg, dp and com are registered; they reflect the new slot one cycle after the slot tick.
REQ-021 Decode: 0..9 standard 7-segment patterns; any snapshot value >9 (or >7 on 3-bit digits padded to 4 bits) shows dash (g only, 7'b1000000).
REQ-022 Leading-zero blank: in slot 3, if snapshot lz_blank=1 and snapshot hr_ten=0, com=4'b1111 and seg=0.
REQ-023 dp=1 only in slot 2 when snapshot colon_on=1 and digit not blanked by blink.
REQ-024 Blink: frame counter counts completed frames 0..BLINK_FRAMES-1, toggling blink phase on wrap; when blink_en=1 and phase=1, com=4'b1111, seg=0, dp=0.
REQ-025 When blink_en=0, phase keeps running but has no effect; deasserting blink_en restores display from next registered update.
REQ-026 Exactly one com bit low at any time except when blanked (then all high).

Reset
REQ-027 rst=1 forces immediately: prescaler 0, slot index 3, snapshot all 0 (lz_blank 0, colon_on 0), frame counter 0, blink phase 0, com=4'b1111, seg=0, dp=0, frame_start=0.
REQ-028 Reset mid-frame abandons the frame; after release, first slot tick occurs SCAN_DIV cycles later and drives slot 2 with the zero snapshot; first frame_start follows after four slot ticks.

Structure
REQ-029 Shared package holds the 7-segment pattern constants (digits 0..9, dash, blank) and the com one-hot-low encodings.
REQ-030 One sub-module, bcd_to_seg: combinational 4-bit BCD to 7-bit pattern with dash for >9; instantiated once on the muxed snapshot digit.
REQ-031 Top-level holds prescaler, slot index, snapshot, blink counter and output registers.

Verification (SCAN_DIV=4, BLINK_FRAMES=2)
REQ-032 Inputs 1,2,3,4, lz_blank=0 -> com sequence 0111,1011,1101,1110 each held 4 cycles; seg 0x06,0x5B,0x4F,0x66.
REQ-033 hr_ten=0, lz_blank=1 -> slot 3 com=1111, seg=0; other three digits normal.
REQ-034 Change mn_one 4->9 during slot 2 -> mn_one slot still shows 4 this frame, 9 after next frame_start.
REQ-035 mn_one=4'hC -> seg=7'b1000000 in slot 0.
REQ-036 blink_en=1 -> display alternates 2 frames on, 2 frames all com=1111; colon_on=1 gives dp=1 only in slot 2 of on-frames.
REQ-037 Assert rst for 3 cycles mid-slot 1 -> outputs reset asynchronously; first com change (1011) exactly 4 cycles after release.

Source files
------------

// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared segment patterns, digit-common encodings and snapshot type
package seg_scan_driver_pkg;
    // Segment order is {g,f,e,d,c,b,a}, active-high; entry i is the glyph for digit i.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    // Active-low one-hot commons indexed by slot; slot 3 drives hr_ten on bit 3.
    localparam logic [3:0][3:0] COM_SLOT = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    localparam logic [3:0] COM_OFF = 4'b1111;
    typedef struct packed {
        logic [2:0] hr_ten;
        logic [3:0] hr_one;
        logic [2:0] mn_ten;
        logic [3:0] mn_one;
        logic       lz_blank;
        logic       colon_on;
    } snap_t;
endpackage

// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: time digits and display controls in, multiplexed segment drive out
// master: drives hr_ten/hr_one/mn_ten/mn_one, lz_blank, blink_en, colon_on; observes display
// slave : the scan driver, producing seg, dp, com and frame_start
interface seg_scan_driver_if;
    logic [2:0] hr_ten;
    logic [3:0] hr_one;
    logic [2:0] mn_ten;
    logic [3:0] mn_one;
    logic       lz_blank;
    logic       blink_en;
    logic       colon_on;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] com;
    logic       frame_start;
    modport master (
        output hr_ten, hr_one, mn_ten, mn_one, lz_blank, blink_en, colon_on,
        input  seg, dp, com, frame_start
    );
    modport slave (
        input  hr_ten, hr_one, mn_ten, mn_one, lz_blank, blink_en, colon_on,
        output seg, dp, com, frame_start
    );
endinterface

// File: rtl/seg_scan_driver_bcd_to_seg.sv
// bcd_to_seg: combinational BCD digit to 7-segment glyph, dash for codes above 9
// bcd: 4-bit digit in; pat: {g,f,e,d,c,b,a} active-high out
module bcd_to_seg
    import seg_scan_driver_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pat
);
    assign pat = bcd > 4'd9 ? SEG_DASH : SEG_DIGITS[bcd];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 4-digit multiplexed HH:MM display scanner with snapshot, blanking and blink
// clk: system clock; rst: async active-high reset
// bus (slave): digit/control inputs, registered seg/dp/com, frame_start pulse on snapshot
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_driver_if.slave   bus
);
    localparam logic [15:0] DIV_MAX = 16'(SCAN_DIV - 1);
    localparam logic [7:0]  FR_MAX  = 8'(BLINK_FRAMES - 1);
    logic [15:0] presc;
    logic [1:0]  slot, slot_n;
    logic [7:0]  fcnt;
    logic        phase, phase_n;
    snap_t       snap, snap_n, live;
    logic        tick, wrap, off, lz_hide;
    logic [3:0]  digit;
    logic [6:0]  pat;
    assign tick = presc == DIV_MAX;
    assign wrap = tick && slot == 2'd0;
    assign bus.frame_start = wrap;
    assign slot_n = slot - 2'd1;
    assign live = {bus.hr_ten, bus.hr_one, bus.mn_ten, bus.mn_one, bus.lz_blank, bus.colon_on};
    // Outputs are computed from the values the state takes at this tick, so the
    // first slot of a frame already shows the snapshot being captured.
    assign snap_n = wrap ? live : snap;
    assign phase_n = wrap && fcnt == FR_MAX ? ~phase : phase;
    assign digit = slot_n == 2'd3 ? {1'b0, snap_n.hr_ten} :
                   slot_n == 2'd2 ? snap_n.hr_one :
                   slot_n == 2'd1 ? {1'b0, snap_n.mn_ten} : snap_n.mn_one;
    assign off = bus.blink_en && phase_n;
    assign lz_hide = slot_n == 2'd3 && snap_n.lz_blank && snap_n.hr_ten == 3'd0;
    bcd_to_seg u_dec (.bcd(digit), .pat(pat));
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc   <= '0;
            slot    <= 2'd3;
            snap    <= '0;
            fcnt    <= '0;
            phase   <= 1'b0;
            bus.com <= COM_OFF;
            bus.seg <= SEG_BLANK;
            bus.dp  <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            if (tick) begin
                slot    <= slot_n;
                snap    <= snap_n;
                phase   <= phase_n;
                fcnt    <= !wrap ? fcnt : fcnt == FR_MAX ? '0 : fcnt + 8'd1;
                bus.com <= off || lz_hide ? COM_OFF : COM_SLOT[slot_n];
                bus.seg <= off || lz_hide ? SEG_BLANK : pat;
                bus.dp  <= !off && slot_n == 2'd2 && snap_n.colon_on;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed scoreboard bench for seg_scan_driver (SCAN_DIV=4, BLINK_FRAMES=2)
module tb_seg_scan_driver;
    logic clk = 1'b0;
    logic rst = 1'b0;
    seg_scan_driver_if bus();
    seg_scan_driver #(.SCAN_DIV(4), .BLINK_FRAMES(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [11:0] q[$];
    logic [11:0] last;
    logic [1:0]  cur_slot;
    logic [2:0]  m_hr_ten;
    logic [3:0]  m_hr_one;
    logic [2:0]  m_mn_ten;
    logic [3:0]  m_mn_one;
    logic        m_lz, m_colon, m_phase;
    int          m_fcnt;

    task automatic check(input string tag, input logic [11:0] act, input logic [11:0] want);
        checks++;
        assert (act === want) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, act, want);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'd0: glyph = 7'h3F;
            4'd1: glyph = 7'h06;
            4'd2: glyph = 7'h5B;
            4'd3: glyph = 7'h4F;
            4'd4: glyph = 7'h66;
            4'd5: glyph = 7'h6D;
            4'd6: glyph = 7'h7D;
            4'd7: glyph = 7'h07;
            4'd8: glyph = 7'h7F;
            4'd9: glyph = 7'h6F;
            default: glyph = 7'h40;
        endcase
    endfunction

    // Expected {com,seg,dp} for a slot given the model snapshot and live blink_en.
    function automatic logic [11:0] model(input logic [1:0] s);
        logic [3:0] d, c;
        d = s == 2'd3 ? {1'b0, m_hr_ten} : s == 2'd2 ? m_hr_one :
            s == 2'd1 ? {1'b0, m_mn_ten} : m_mn_one;
        c = s == 2'd3 ? 4'b0111 : s == 2'd2 ? 4'b1011 : s == 2'd1 ? 4'b1101 : 4'b1110;
        if ((bus.blink_en && m_phase) || (s == 2'd3 && m_lz && m_hr_ten == 3'd0))
            return 12'hF00;
        return {c, glyph(d), s == 2'd2 && m_colon};
    endfunction

    task automatic capture();
        m_hr_ten = bus.hr_ten;
        m_hr_one = bus.hr_one;
        m_mn_ten = bus.mn_ten;
        m_mn_one = bus.mn_one;
        m_lz     = bus.lz_blank;
        m_colon  = bus.colon_on;
        if (m_fcnt == 1) begin
            m_fcnt  = 0;
            m_phase = ~m_phase;
        end else m_fcnt++;
        for (int s = 3; s >= 0; s--) q.push_back(model(2'(s)));
    endtask

    task automatic model_reset();
        m_hr_ten = '0; m_hr_one = '0; m_mn_ten = '0; m_mn_one = '0;
        m_lz = 1'b0; m_colon = 1'b0; m_phase = 1'b0; m_fcnt = 0;
        q.delete();
        cur_slot = 2'd3;
        last = 12'hF00;
        for (int s = 2; s >= 0; s--) q.push_back(model(2'(s)));
    endtask

    // Called right after a slot update; advances through the next slot's tick and update.
    task automatic next_slot(input string tag);
        logic [11:0] e;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "/hold"}, {bus.com, bus.seg, bus.dp}, last);
        check({tag, "/frame_start"}, 12'(bus.frame_start), 12'(cur_slot == 2'd0));
        if (cur_slot == 2'd0) capture();
        cur_slot = cur_slot - 2'd1;
        @(posedge clk);
        #1;
        e = 'x;
        if (q.size() != 0) e = q.pop_front();
        check(tag, {bus.com, bus.seg, bus.dp}, e);
        last = e;
    endtask

    task automatic run_frames(input int n, input string tag);
        repeat (4 * n) next_slot(tag);
    endtask

    task automatic check_off(input string tag);
        check({tag, "/out"}, {bus.com, bus.seg, bus.dp}, 12'hF00);
        check({tag, "/frame_start"}, 12'(bus.frame_start), 12'h0);
    endtask

    initial begin
        bus.hr_ten = 3'd1; bus.hr_one = 4'd2; bus.mn_ten = 3'd3; bus.mn_one = 4'd4;
        bus.lz_blank = 1'b0; bus.blink_en = 1'b0; bus.colon_on = 1'b0;
        #2 rst = 1'b1;
        #1 check_off("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        model_reset();
        repeat (3) next_slot("zero_snap");
        run_frames(1, "digits");
        bus.hr_ten = 3'd0; bus.lz_blank = 1'b1; bus.colon_on = 1'b1;
        run_frames(1, "lz_colon");
        bus.hr_ten = 3'd1; bus.lz_blank = 1'b0; bus.colon_on = 1'b0;
        repeat (2) next_slot("snap_hold");
        bus.mn_one = 4'd9;
        repeat (2) next_slot("snap_hold");
        run_frames(1, "snap_new");
        bus.mn_one = 4'hC;
        run_frames(1, "dash");
        bus.mn_one = 4'd4; bus.blink_en = 1'b1; bus.colon_on = 1'b1;
        run_frames(4, "blink");
        bus.blink_en = 1'b0;
        run_frames(1, "unblink");
        repeat (3) next_slot("pre_rst");
        @(posedge clk);
        #2 rst = 1'b1;
        bus.hr_ten = 3'd2; bus.hr_one = 4'd3; bus.mn_ten = 3'd5; bus.mn_one = 4'd7;
        bus.colon_on = 1'b1;
        #1 check_off("mid_reset");
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        repeat (3) next_slot("post_rst");
        run_frames(1, "post_rst_frame");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
